// File: rtl/regn_fifo_pkg.sv
// Shared definitions for the register-based FWFT buffer between the UART and host logic.
// Holds the UART width/depth defaults and the occupancy classification.
package regn_fifo_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  function automatic occ_e occ_of(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0)
      return OCC_EMPTY;
    else if (cnt == depth)
      return OCC_FULL;
    else
      return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/regn_fifo_regn.sv
// WIDTH-bit loadable register: captures Din when ld is high, otherwise holds.
module regn #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      Dout <= '0;
    else if (ld)
      Dout <= Din;
  end

endmodule

// File: rtl/regn_fifo.sv
// WIDTH x DEPTH first-word-fall-through buffer built from loadable registers.
// Occupancy is tracked only by count; ovf/unf are sticky until reset or clr.
module regn_fifo
  import regn_fifo_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = UART_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] Din,
  input  logic             rd,
  output logic [WIDTH-1:0] Dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_nxt;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] mem [DEPTH];

  // A full buffer still accepts a push when the head is popped in the same cycle.
  assign push = ld && (!full || rd);
  assign pop  = rd && !empty;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      empty <= (occ_of(int'(count_nxt), DEPTH) == OCC_EMPTY);
      full  <= (occ_of(int'(count_nxt), DEPTH) == OCC_FULL);
      if (ld && full && !rd)
        ovf <= 1'b1;
      if (rd && empty)
        unf <= 1'b1;
    end
  end

  // Storage entries are never reset; only the control state is.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    regn #(.WIDTH(WIDTH)) u_regn (
      .clk   (clk),
      .reset (1'b0),
      .ld    (push && (wr_ptr == AW'(i))),
      .Din   (Din),
      .Dout  (mem[i])
    );
  end

  assign Dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_regn_fifo.sv
// Scoreboard bench for regn_fifo: a DEPTH=4 and a DEPTH=16 instance share stimulus;
// expected data is queued on accepted pushes and compared against Dout every cycle.
module tb_regn_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       ld;
  logic [7:0] din;
  logic       rd;

  logic [7:0] dout4,  dout16;
  logic       empty4, empty16;
  logic       full4,  full16;
  logic [2:0] count4;
  logic [4:0] count16;
  logic       ovf4,   ovf16;
  logic       unf4,   unf16;

  logic       sel16;
  int         depth;
  logic [7:0] sb [$];
  logic       m_ovf;
  logic       m_unf;
  int         pushed;
  int         n_chk;
  int         n_pass;

  always #5 clk = ~clk;

  regn_fifo #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .clr(clr), .ld(ld), .Din(din), .rd(rd),
    .Dout(dout4), .empty(empty4), .full(full4), .count(count4), .ovf(ovf4), .unf(unf4)
  );

  regn_fifo #(.WIDTH(8), .DEPTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .clr(clr), .ld(ld), .Din(din), .rd(rd),
    .Dout(dout16), .empty(empty16), .full(full16), .count(count16), .ovf(ovf16), .unf(unf16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outs();
    logic [7:0] head;
    head = (sb.size() != 0) ? sb[0] : 8'h00;
    if (sel16) begin
      chk("count", 32'(count16), 32'(sb.size()));
      chk("empty", 32'(empty16), 32'(sb.size() == 0));
      chk("full",  32'(full16),  32'(sb.size() == depth));
      chk("ovf",   32'(ovf16),   32'(m_ovf));
      chk("unf",   32'(unf16),   32'(m_unf));
      chk("dout",  32'(dout16),  32'(head));
    end else begin
      chk("count", 32'(count4), 32'(sb.size()));
      chk("empty", 32'(empty4), 32'(sb.size() == 0));
      chk("full",  32'(full4),  32'(sb.size() == depth));
      chk("ovf",   32'(ovf4),   32'(m_ovf));
      chk("unf",   32'(unf4),   32'(m_unf));
      chk("dout",  32'(dout4),  32'(head));
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the reference model, then check after the edge.
  task automatic step(input logic l, input logic [7:0] d, input logic r, input logic c);
    bit is_full;
    bit is_empty;
    ld  = l;
    din = d;
    rd  = r;
    clr = c;
    @(posedge clk);
    is_full  = (sb.size() == depth);
    is_empty = (sb.size() == 0);
    if (c) begin
      model_clear();
    end else begin
      if (l && is_full && !r) m_ovf = 1'b1;
      if (r && is_empty)      m_unf = 1'b1;
      if (r && !is_empty)     void'(sb.pop_front());
      if (l && (!is_full || r)) begin
        sb.push_back(d);
        pushed++;
      end
    end
    @(negedge clk);
    ld  = 1'b0;
    rd  = 1'b0;
    clr = 1'b0;
    check_outs();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outs();
  endtask

  initial begin
    logic [7:0] pat [4];
    bit         l;
    bit         r;
    n_chk  = 0;
    n_pass = 0;
    pushed = 0;
    sel16  = 1'b0;
    depth  = 4;
    reset  = 1'b1;
    clr    = 1'b0;
    ld     = 1'b0;
    rd     = 1'b0;
    din    = 8'h00;
    model_clear();
    pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outs();

    // async reset mid-run with three entries held
    for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_outs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outs();

    // fill to full and drain in order
    for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0, 1'b0);
    chk("full_after_fill", 32'(full4), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // overflow when full, then simultaneous push/pop while full
    for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("dout_after_ldrd", 32'(dout4), 32'h0000_00B2);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // underflow, then ld+rd while empty pushes only
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    chk("dout_3c", 32'(dout4), 32'h0000_003C);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // clear with count=2 and ovf set; ld in the same cycle is ignored
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // DEPTH=16: random traffic with stalls across pointer wrap
    sel16 = 1'b1;
    depth = 16;
    pulse_reset();
    pushed = 0;
    for (int cyc = 0; cyc < 2000 && (pushed < 40 || sb.size() > 0); cyc++) begin
      l = (pushed < 40) && ($urandom_range(0, 3) != 0);
      r = (pushed >= 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      step(l, 8'($urandom), r, 1'b0);
    end
    chk("drained_count", 32'(count16), 32'd0);
    chk("pushed_total", 32'(pushed), 32'd40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
